// File: rtl/combi_fetch_buffer.sv
// Instruction-fetch producer: issues sequential word fetches, tracks outstanding
// requests and presents returned words in order to the decode stage.
module combi_fetch_buffer #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req,
    output logic [31:0]               imem_addr,
    input  logic                      imem_gnt,
    input  logic                      imem_rvalid,
    input  logic [31:0]               imem_rdata,
    input  logic                      stall_i,
    input  logic                      redirect_i,
    input  logic [31:0]               redirect_pc,
    output logic [31:0]               instr_o,
    output logic [31:0]               pc_o,
    output logic                      valid_o,
    output logic [$clog2(DEPTH):0]    inflight_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   q_pc_q    [DEPTH];
    logic [31:0]   q_instr_q [DEPTH];
    logic [31:0]   pcf_q     [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] pcf_rd_q, pcf_rd_d, pcf_wr_q, pcf_wr_d;
    logic [CW-1:0] count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
    logic          issue, resp_drop, resp_keep, push, pop, valid;

    // Credit covers both buffered and pending words, so every kept response has a slot.
    assign imem_req  = ~rst & (({1'b0, count_q} + {1'b0, inflight_q}) < LIMIT);
    assign imem_addr = fetch_pc_q;
    assign issue     = imem_req & imem_gnt;
    assign resp_drop = imem_rvalid & (drop_q != '0);
    assign resp_keep = imem_rvalid & (drop_q == '0) & (inflight_q != '0);
    assign push      = resp_keep & ~redirect_i;
    assign valid     = ~rst & (count_q != '0);
    assign pop       = valid & ~stall_i & ~redirect_i;

    assign valid_o    = valid;
    assign instr_o    = valid ? q_instr_q[rd_ptr_q] : NOP_INSTR;
    assign pc_o       = valid ? q_pc_q[rd_ptr_q] : 32'h0000_0000;
    assign inflight_o = inflight_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        pcf_rd_d   = pcf_rd_q;
        pcf_wr_d   = pcf_wr_q;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            pcf_rd_d   = '0;
            pcf_wr_d   = '0;
            inflight_d = '0;
            // Everything still pending, including a request issued right now, becomes stale.
            drop_d = drop_q - CW'(resp_drop) + inflight_q - CW'(resp_keep) + CW'(issue);
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                pcf_wr_d   = pcf_wr_q + AW'(1);
            end
            if (resp_keep) pcf_rd_d = pcf_rd_q + AW'(1);
            if (push)      wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)       rd_ptr_d = rd_ptr_q + AW'(1);
            count_d    = count_q + CW'(push) - CW'(pop);
            inflight_d = inflight_q + CW'(issue) - CW'(resp_keep);
            drop_d     = drop_q - CW'(resp_drop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            pcf_rd_q   <= '0;
            pcf_wr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            pcf_rd_q   <= pcf_rd_d;
            pcf_wr_q   <= pcf_wr_d;
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers and counters.
    always_ff @(posedge clk) begin
        if (issue && !redirect_i) pcf_q[pcf_wr_q] <= fetch_pc_q;
        if (push) begin
            q_pc_q[wr_ptr_q]    <= pcf_q[pcf_rd_q];
            q_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

    a_credit:   assert property (@(posedge clk) disable iff (rst)
                    ({1'b0, count_q} + {1'b0, inflight_q}) <= LIMIT);
    a_inflight: assert property (@(posedge clk) disable iff (rst) {1'b0, inflight_q} <= LIMIT);
    a_drop:     assert property (@(posedge clk) disable iff (rst) {1'b0, drop_q} <= LIMIT);

endmodule

// File: tb/tb_combi_fetch_buffer.sv
// Scoreboard bench for combi_fetch_buffer: a stimulus task drives memory and
// control, pushing expected words; a negedge monitor checks every consumed word.
module tb_combi_fetch_buffer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic [2:0]  inflight_o;

    combi_fetch_buffer #(
        .DEPTH(DEPTH), .RESET_PC(RPC), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc(redirect_pc),
        .instr_o(instr_o), .pc_o(pc_o), .valid_o(valid_o), .inflight_o(inflight_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;

    mem_t        mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] model_pc = RPC;
    logic [31:0] mon_e;
    int          cyc = 0;
    int          lat = 1;
    int          n_checks = 0;
    int          n_fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // One clock cycle: present memory response and controls, record any issue.
    task automatic step(input logic gnt, input logic stall, input logic redir,
                        input logic [31:0] rpc);
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (rst) begin
            mem_q.delete();
            exp_q.delete();
            model_pc = RPC;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0].addr | 32'hA000_0000;
            mem_q.delete(0);
        end
        imem_gnt    = gnt;
        stall_i     = stall;
        redirect_i  = redir;
        redirect_pc = rpc;
        #1;
        if (imem_req && gnt) begin
            check("issue_addr", imem_addr, model_pc);
            mem_q.push_back('{imem_addr, cyc + lat});
            exp_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
        end
        if (redir) begin
            exp_q.delete();
            model_pc = rpc & 32'hFFFF_FFFC;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input string name, input logic gnt, input logic stall);
        int n = 0;
        while (!valid_o && n < 20) begin
            step(gnt, stall, 1'b0, 32'h0);
            n++;
        end
        n_checks++;
        if (!valid_o) begin
            n_fails++;
            $display("FAIL %s: valid_o got 0 after 20 cycles, required 1", name);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && valid_o && !stall_i && !redirect_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL pop_unexpected: got pc 0x%08h, required no entry", pc_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("pop_pc", pc_o, mon_e);
                check("pop_instr", instr_o, mon_e | 32'hA000_0000);
                $display("pop pc=0x%08h instr=0x%08h", pc_o, instr_o);
            end
        end
    end

    initial begin
        // Reset state
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_instr", instr_o, NOP);
        check("rst_pc", pc_o, 32'h0);
        check("rst_inflight", 32'(inflight_o), 32'd0);

        // Startup latency and back-to-back stream
        rst = 1'b0;
        #1;
        check("c1_req", 32'(imem_req), 32'd1);
        check("c1_valid", 32'(valid_o), 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("c2_valid", 32'(valid_o), 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("c3_valid", 32'(valid_o), 32'd1);
        check("c3_pc", pc_o, 32'h0);
        check("c3_instr", instr_o, 32'hA000_0000);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("c4_pc", pc_o, 32'h4);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("c5_pc", pc_o, 32'h8);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("c6_pc", pc_o, 32'hC);
        step(1'b1, 1'b0, 1'b0, 32'h0);

        // Stall for 10 cycles: queue fills, requests stop, head holds
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        check("stall_pc", pc_o, 32'h10);
        check("stall_valid", 32'(valid_o), 32'd1);
        check("stall_req", 32'(imem_req), 32'd0);
        check("stall_inflight", 32'(inflight_o), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect with two outstanding requests on a 3-cycle memory
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        check("drain_valid", 32'(valid_o), 32'd0);
        lat = 3;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("pre_redir_inflight", 32'(inflight_o), 32'd2);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0103);
        check("redir_valid", 32'(valid_o), 32'd0);
        check("redir_inflight", 32'(inflight_o), 32'd0);
        check("redir_addr", imem_addr, 32'h100);
        wait_valid("redir_wait", 1'b1, 1'b0);
        check("redir_pc0", pc_o, 32'h100);
        check("redir_instr0", instr_o, 32'hA000_0100);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("redir_pc1", pc_o, 32'h104);

        // Redirect together with stall while full
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        lat = 1;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        check("full_valid", 32'(valid_o), 32'd1);
        check("full_req", 32'(imem_req), 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0400);
        check("rs_valid", 32'(valid_o), 32'd0);
        check("rs_pc", pc_o, 32'h0);
        check("rs_instr", instr_o, NOP);
        check("rs_req", 32'(imem_req), 32'd1);
        check("rs_addr", imem_addr, 32'h400);
        wait_valid("rs_wait", 1'b1, 1'b0);
        check("rs_pc0", pc_o, 32'h400);

        // Toggling grant: address advances only on granted cycles
        step(1'b0, 1'b0, 1'b1, 32'h0000_0800);
        for (int i = 0; i < 12; i++) begin
            check("tog_addr", imem_addr, 32'h800 + 32'(4 * ((i + 1) / 2)));
            step((i % 2) == 0, 1'b0, 1'b0, 32'h0);
        end

        // Address wrap, with low redirect bits ignored
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        wait_valid("wrap_wait", 1'b1, 1'b0);
        check("wrap_pc0", pc_o, 32'hFFFF_FFFC);
        check("wrap_instr0", instr_o, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("wrap_pc1", pc_o, 32'h0);
        check("wrap_instr1", instr_o, 32'hA000_0000);

        // Random grant/stall/redirect run on a 2-cycle memory
        lat = 2;
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 19) == 0, $urandom & 32'hFFFF_FFF3);
            n_checks++;
            if (inflight_o > 3'(DEPTH)) begin
                n_fails++;
                $display("FAIL inflight_bound: got %0d, required <= %0d", inflight_o, DEPTH);
            end
        end

        // Drain: every issued word must have been consumed
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        check("final_exp_empty", 32'(exp_q.size()), 32'd0);
        check("final_valid", 32'(valid_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
